hq2x_line_scheduler: RTL and testbench
======================================

HQ2X_LINE_SCHEDULER -- requirements
Module: hq2x_line_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning depth of the input pixel FIFO (power of two, 4..64).
REQ-002 SHALL have parameter VISIBLE_LINES, default 240, meaning PPU lines per frame before the flush line.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  system clock; every register samples on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ppu_frame_start  in  1  single-cycle pulse marking the start of a PPU frame.
REQ-007 ppu_line_start  in  1  single-cycle pulse marking the start of a PPU visible line.
REQ-008 ppu_pixel  in  15  BGR555 pixel from the PPU.
REQ-009 ppu_pixel_valid  in  1  ppu_pixel is valid this cycle; push into the FIFO.
REQ-010 vga_x  in  9  output column 0..511 requested by the display side.
REQ-011 vga_line_odd  in  1  selects the odd output line of the current pair.
REQ-012 hq_inputpixel  out  15  pixel presented to the scaler.
REQ-013 hq_reset_frame  out  1  frame reset strobe to the scaler.
REQ-014 hq_reset_line  out  1  line reset strobe to the scaler.
REQ-015 hq_read_x  out  10  {vga_line_odd, vga_x}, registered.
REQ-016 busy  out  1  high in SYNC or RUN.
REQ-017 line_count  out  8  lines issued to the scaler this frame, including the flush line.
REQ-018 err_overflow, err_underflow  out  1 each  sticky FIFO error flags.

Function
REQ-019 FSM states SHALL be IDLE, SYNC, RUN and FLUSH_WAIT.
REQ-020 IDLE -> SYNC SHALL occur on ppu_line_start when line_count < VISIBLE_LINES; otherwise the pulse SHALL be ignored.
REQ-021 SYNC SHALL assert hq_reset_line for exactly 2 cycles, then enter RUN with phase=0 and slot=0.
REQ-022 RUN SHALL run a 2-bit phase counter (0..3) and a 9-bit slot counter (0..257); slot increments when phase wraps 3->0. RUN SHALL last 1032 cycles.
REQ-023 At phase 2 with slot 0..255, the FSM SHALL pop one FIFO entry into the hq_inputpixel register: 256 pops per line.
REQ-024 hq_inputpixel SHALL stay stable from the pop until the next pop.
REQ-025 At the end of RUN, line_count SHALL increment. If the new value equals VISIBLE_LINES and no flush has run this frame, the FSM SHALL enter FLUSH_WAIT; otherwise it SHALL go to IDLE.
REQ-026 FLUSH_WAIT SHALL wait 4 cycles, then enter SYNC for one self-issued flush line with FIFO pops suppressed and hq_inputpixel forced to 0. After it, the FSM SHALL return to IDLE.
REQ-027 ppu_frame_start SHALL, in any state, produce a 1-cycle hq_reset_frame on the next cycle and flush the FIFO. It SHALL also clear line_count, the flush flag and both error flags, and force IDLE.
REQ-028 If ppu_frame_start and ppu_line_start coincide, the frame action SHALL win and the line start SHALL be dropped.
REQ-029 A ppu_line_start arriving in SYNC, RUN or FLUSH_WAIT SHALL be ignored and SHALL set err_underflow.
REQ-030 A push into a full FIFO SHALL be dropped and SHALL set err_overflow; a simultaneous push and pop on a full FIFO SHALL succeed.
REQ-031 A pop from an empty FIFO SHALL keep the previous hq_inputpixel and SHALL set err_underflow.
REQ-032 The FIFO occupancy counter SHALL be clog2(FIFO_DEPTH)+1 bits wide; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-033 hq_read_x SHALL have 1-cycle latency from vga_x/vga_line_odd.

Reset
REQ-034 On reset, the FSM SHALL enter IDLE with phase, slot, line_count, FIFO pointers and occupancy all 0.
REQ-035 On reset, hq_inputpixel, hq_read_x, busy and both error flags SHALL be 0.
REQ-036 On reset, hq_reset_frame SHALL be 1 and SHALL deassert on the first clock after reset release.
REQ-037 On reset, hq_reset_line SHALL be 0.
REQ-038 Reset asserted mid-line SHALL abandon the line with no further pops.

Structure
REQ-039 A shared package SHALL hold the FSM state enum, the slot constants 258 and 256, SYNC_CYCLES=2 and FLUSH_GAP=4.
REQ-040 The FIFO SHALL be a sub-module named pixel_fifo (parameterised depth, 15-bit data, full/empty/count outputs); the FSM, counters and strobes SHALL remain in the top module.

Verification
REQ-041 Frame start, then line start with 256 pixels pre-pushed -> hq_reset_line high 2 cycles, 256 pops at phase 2, busy high 1034 cycles, line_count=1.
REQ-042 240 lines -> a flush line starts 4 cycles after RUN ends with hq_inputpixel=0; line_count=241; a 241st ppu_line_start is ignored.
REQ-043 Push 17 pixels with FIFO_DEPTH=16 and no pops -> err_overflow=1, occupancy=16, 17th pixel lost.
REQ-044 Line start with empty FIFO -> err_underflow=1, hq_inputpixel holds its last value, RUN still lasts 1032 cycles.
REQ-045 ppu_frame_start at slot 100 of RUN -> hq_reset_frame pulses next cycle, IDLE, FIFO empty, flags and line_count cleared.
REQ-046 Reset asserted mid-RUN and released -> hq_reset_frame=1 during reset, all other outputs 0, and the first clock after release shows hq_reset_frame=0.

Source files
------------

// File: rtl/hq2x_line_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// hq2x_line_scheduler_pkg : shared FSM state encoding and line timing constants
// Revision 1.0
// ============================================================================
package hq2x_line_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SYNC       = 2'd1,
        ST_RUN        = 2'd2,
        ST_FLUSH_WAIT = 2'd3
    } state_t;

    localparam int unsigned SLOTS_PER_LINE  = 258;
    localparam int unsigned PIXELS_PER_LINE = 256;
    localparam int unsigned SYNC_CYCLES     = 2;
    localparam int unsigned FLUSH_GAP       = 4;

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
// pixel_fifo : power-of-two FIFO with synchronous clear; a pop frees room for
//              a same-cycle push even when full.   Revision 1.0
// ============================================================================
module pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_full);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/hq2x_line_scheduler.sv
`default_nettype none
// ============================================================================
// hq2x_line_scheduler : buffers PPU pixels and paces one 256-pixel line per
//                       1032-cycle slot into the HQ2x scaler.   Revision 1.0
// ============================================================================
module hq2x_line_scheduler
    import hq2x_line_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int VISIBLE_LINES = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ppu_frame_start,
    input  logic        ppu_line_start,
    input  logic [14:0] ppu_pixel,
    input  logic        ppu_pixel_valid,
    input  logic [8:0]  vga_x,
    input  logic        vga_line_odd,
    output logic [14:0] hq_inputpixel,
    output logic        hq_reset_frame,
    output logic        hq_reset_line,
    output logic [9:0]  hq_read_x,
    output logic        busy,
    output logic [7:0]  line_count,
    output logic        err_overflow,
    output logic        err_underflow
);
    localparam logic [8:0] c_slot_last  = 9'(SLOTS_PER_LINE - 1);
    localparam logic [8:0] c_pix_slots  = 9'(PIXELS_PER_LINE);
    localparam logic [1:0] c_sync_last  = 2'(SYNC_CYCLES - 1);
    localparam logic [1:0] c_gap_last   = 2'(FLUSH_GAP - 1);
    localparam logic [7:0] c_visible    = 8'(VISIBLE_LINES);

    state_t      r_state;
    logic [1:0]  r_phase;
    logic [8:0]  r_slot;
    logic [1:0]  r_cnt;
    logic [7:0]  r_line_count;
    logic        r_flush_done;
    logic        r_flush_line;
    logic [14:0] r_pixel;
    logic        r_reset_frame;
    logic        r_reset_line;
    logic        r_busy;
    logic [9:0]  r_read_x;
    logic        r_err_overflow;
    logic        r_err_underflow;

    logic                          w_pop_req;
    logic                          w_pop_ok;
    logic                          w_fifo_ovf;
    logic                          w_fifo_unf;
    logic [14:0]                   w_fifo_rdata;
    logic                          w_fifo_full;
    logic                          w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   w_fifo_count;
    logic [7:0]                    w_line_count_next;

    // Frame start outranks the pop so an aborted line never consumes a pixel.
    assign w_pop_req = (r_state == ST_RUN) && (r_phase == 2'd2) && (r_slot < c_pix_slots)
                       && !r_flush_line && !ppu_frame_start;
    assign w_pop_ok  = w_pop_req && !w_fifo_empty;
    assign w_fifo_unf = w_pop_req && (w_fifo_count == '0);
    assign w_fifo_ovf = ppu_pixel_valid && w_fifo_full && !w_pop_ok;
    assign w_line_count_next = r_line_count + 8'd1;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (15)
    ) u_pixel_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clear (ppu_frame_start),
        .i_push  (ppu_pixel_valid),
        .i_wdata (ppu_pixel),
        .i_pop   (w_pop_req),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_read_x <= '0;
        end else begin
            r_read_x <= {vga_line_odd, vga_x};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_phase         <= '0;
            r_slot          <= '0;
            r_cnt           <= '0;
            r_line_count    <= '0;
            r_flush_done    <= 1'b0;
            r_flush_line    <= 1'b0;
            r_pixel         <= '0;
            r_reset_frame   <= 1'b1;
            r_reset_line    <= 1'b0;
            r_busy          <= 1'b0;
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            r_reset_frame <= ppu_frame_start;
            if (ppu_frame_start) begin
                r_state         <= ST_IDLE;
                r_phase         <= '0;
                r_slot          <= '0;
                r_cnt           <= '0;
                r_line_count    <= '0;
                r_flush_done    <= 1'b0;
                r_flush_line    <= 1'b0;
                r_reset_line    <= 1'b0;
                r_busy          <= 1'b0;
                r_err_overflow  <= 1'b0;
                r_err_underflow <= 1'b0;
            end else begin
                if (w_fifo_ovf) r_err_overflow <= 1'b1;
                if (w_fifo_unf || (ppu_line_start && r_state != ST_IDLE)) r_err_underflow <= 1'b1;
                if (w_pop_ok)   r_pixel <= w_fifo_rdata;
                case (r_state)
                    ST_IDLE: begin
                        if (ppu_line_start && (r_line_count < c_visible)) begin
                            r_state      <= ST_SYNC;
                            r_reset_line <= 1'b1;
                            r_busy       <= 1'b1;
                            r_cnt        <= '0;
                        end
                    end
                    ST_SYNC: begin
                        if (r_cnt == c_sync_last) begin
                            r_state      <= ST_RUN;
                            r_reset_line <= 1'b0;
                            r_phase      <= '0;
                            r_slot       <= '0;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                    ST_RUN: begin
                        r_phase <= r_phase + 2'd1;
                        if (r_phase == 2'd3) begin
                            if (r_slot == c_slot_last) begin
                                r_line_count <= w_line_count_next;
                                r_busy       <= 1'b0;
                                r_flush_line <= 1'b0;
                                r_cnt        <= '0;
                                // The frame's last PPU line is followed by one self-issued flush line.
                                if ((w_line_count_next == c_visible) && !r_flush_done) begin
                                    r_state      <= ST_FLUSH_WAIT;
                                    r_flush_done <= 1'b1;
                                end else begin
                                    r_state <= ST_IDLE;
                                end
                            end else begin
                                r_slot <= r_slot + 9'd1;
                            end
                        end
                    end
                    ST_FLUSH_WAIT: begin
                        if (r_cnt == c_gap_last) begin
                            r_state      <= ST_SYNC;
                            r_reset_line <= 1'b1;
                            r_busy       <= 1'b1;
                            r_cnt        <= '0;
                            r_flush_line <= 1'b1;
                            r_pixel      <= '0;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign hq_inputpixel  = r_pixel;
    assign hq_reset_frame = r_reset_frame;
    assign hq_reset_line  = r_reset_line;
    assign hq_read_x      = r_read_x;
    assign busy           = r_busy;
    assign line_count     = r_line_count;
    assign err_overflow   = r_err_overflow;
    assign err_underflow  = r_err_underflow;

endmodule
`default_nettype wire

// File: tb/tb_hq2x_line_scheduler.sv
`default_nettype none
// ============================================================================
// tb_hq2x_line_scheduler : self-checking bench; line timing is predicted from
//                          cycle offsets and the FIFO is modelled as a queue.
// Revision 1.0
// ============================================================================
module tb_hq2x_line_scheduler;
    localparam int C_DEPTH = 16;
    localparam int C_VIS   = 3;
    localparam int C_LINE_EDGES = 1035;   // start edge .. edge that leaves RUN

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ppu_frame_start = 1'b0;
    logic        ppu_line_start = 1'b0;
    logic [14:0] ppu_pixel = '0;
    logic        ppu_pixel_valid = 1'b0;
    logic [8:0]  vga_x = '0;
    logic        vga_line_odd = 1'b0;
    logic [14:0] hq_inputpixel;
    logic        hq_reset_frame;
    logic        hq_reset_line;
    logic [9:0]  hq_read_x;
    logic        busy;
    logic [7:0]  line_count;
    logic        err_overflow;
    logic        err_underflow;

    always #5 clk = ~clk;

    hq2x_line_scheduler #(
        .FIFO_DEPTH    (C_DEPTH),
        .VISIBLE_LINES (C_VIS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ppu_frame_start (ppu_frame_start),
        .ppu_line_start  (ppu_line_start),
        .ppu_pixel       (ppu_pixel),
        .ppu_pixel_valid (ppu_pixel_valid),
        .vga_x           (vga_x),
        .vga_line_odd    (vga_line_odd),
        .hq_inputpixel   (hq_inputpixel),
        .hq_reset_frame  (hq_reset_frame),
        .hq_reset_line   (hq_reset_line),
        .hq_read_x       (hq_read_x),
        .busy            (busy),
        .line_count      (line_count),
        .err_overflow    (err_overflow),
        .err_underflow   (err_underflow)
    );

    typedef struct {
        logic [8:0] x;
        logic       odd;
        logic [9:0] exp_read_x;
    } rx_vec_t;

    int          n_pass = 0;
    int          n_total = 0;
    logic [14:0] q[$];
    logic [14:0] exp_pix = '0;
    bit          exp_ovf = 1'b0;
    bit          exp_unf = 1'b0;
    int          exp_lc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input int pct);
        ppu_pixel_valid = (int'($urandom_range(99)) < pct);
        ppu_pixel       = 15'($urandom());
    endtask

    // Pops are applied before pushes, so a full queue accepts a push on a pop edge.
    task automatic model_push();
        if (ppu_pixel_valid) begin
            if (q.size() < C_DEPTH) q.push_back(ppu_pixel);
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic chk_all_reset_outputs();
        chk("rst_reset_frame", hq_reset_frame, 1);
        chk("rst_reset_line", hq_reset_line, 0);
        chk("rst_pixel", hq_inputpixel, 0);
        chk("rst_read_x", hq_read_x, 0);
        chk("rst_busy", busy, 0);
        chk("rst_line_count", line_count, 0);
        chk("rst_overflow", err_overflow, 0);
        chk("rst_underflow", err_underflow, 0);
    endtask

    // Edge i is counted from the edge that samples the line start (or enters the flush SYNC).
    task automatic run_line(input bit flush, input int push_pct, input int spur_at, input int abort_at);
        for (int i = 0; i < C_LINE_EDGES; i++) begin
            if (i == abort_at) begin
                ppu_line_start  = 1'b0;
                ppu_pixel_valid = 1'b0;
                return;
            end
            ppu_line_start = (!flush && i == 0) || (i == spur_at);
            drive_push(push_pct);
            if (i == spur_at) exp_unf = 1'b1;
            if (!flush && i >= 5 && ((i - 5) % 4) == 0 && ((i - 5) / 4) < 256) begin
                if (q.size() > 0) exp_pix = q.pop_front();
                else exp_unf = 1'b1;
            end
            if (flush && i == 0) exp_pix = '0;
            model_push();
            tick();
            chk("line_busy", busy, int'(i <= 1033));
            chk("line_reset_line", hq_reset_line, int'(i <= 1));
            chk("line_pixel", hq_inputpixel, exp_pix);
        end
        ppu_line_start  = 1'b0;
        ppu_pixel_valid = 1'b0;
        exp_lc++;
        chk("line_count", line_count, exp_lc);
        chk("line_overflow", err_overflow, exp_ovf);
        chk("line_underflow", err_underflow, exp_unf);
    endtask

    task automatic idle_cycles(input int n, input int push_pct);
        for (int i = 0; i < n; i++) begin
            ppu_line_start = 1'b0;
            drive_push(push_pct);
            model_push();
            tick();
            chk("idle_busy", busy, 0);
            chk("idle_reset_line", hq_reset_line, 0);
            chk("idle_pixel", hq_inputpixel, exp_pix);
        end
        ppu_pixel_valid = 1'b0;
    endtask

    task automatic frame_pulse(input bit with_line);
        ppu_frame_start = 1'b1;
        ppu_line_start  = with_line;
        ppu_pixel_valid = 1'b1;
        ppu_pixel       = 15'($urandom());
        q.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        exp_lc  = 0;
        tick();
        ppu_frame_start = 1'b0;
        ppu_line_start  = 1'b0;
        ppu_pixel_valid = 1'b0;
        chk("frame_reset_frame", hq_reset_frame, 1);
        chk("frame_busy", busy, 0);
        chk("frame_reset_line", hq_reset_line, 0);
        chk("frame_line_count", line_count, 0);
        chk("frame_overflow", err_overflow, 0);
        chk("frame_underflow", err_underflow, 0);
        chk("frame_pixel_held", hq_inputpixel, exp_pix);
        tick();
        chk("frame_reset_frame_drop", hq_reset_frame, 0);
        chk("frame_stays_idle", busy, 0);
    endtask

    rx_vec_t     vecs[5];
    logic [9:0]  prev_rx;

    initial begin
        vecs[0] = '{x: 9'd0,   odd: 1'b0, exp_read_x: 10'd0};
        vecs[1] = '{x: 9'd511, odd: 1'b1, exp_read_x: 10'd1023};
        vecs[2] = '{x: 9'd256, odd: 1'b0, exp_read_x: 10'd256};
        vecs[3] = '{x: 9'd1,   odd: 1'b1, exp_read_x: 10'd513};
        vecs[4] = '{x: 9'd300, odd: 1'b1, exp_read_x: 10'd812};

        // Power-on reset
        #1 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all_reset_outputs();
        reset = 1'b0;
        tick();
        chk("release_reset_frame", hq_reset_frame, 0);

        // Display-side address register: value appears only after the next edge
        prev_rx = '0;
        for (int v = 0; v < 5; v++) begin
            vga_x        = vecs[v].x;
            vga_line_odd = vecs[v].odd;
            #1;
            chk("read_x_before_edge", hq_read_x, prev_rx);
            tick();
            chk("read_x", hq_read_x, vecs[v].exp_read_x);
            prev_rx = vecs[v].exp_read_x;
        end

        // 17 pushes into a 16-deep FIFO, then a full line that drains it
        frame_pulse(1'b0);
        for (int k = 0; k < 17; k++) begin
            ppu_pixel_valid = 1'b1;
            ppu_pixel       = 15'($urandom());
            model_push();
            tick();
            chk("overflow_flag_progress", err_overflow, int'(k == 16));
        end
        ppu_pixel_valid = 1'b0;
        chk("overflow_after_17", err_overflow, 1);
        run_line(1'b0, 30, -1, 2000);
        chk("first_line_count", line_count, 1);
        idle_cycles(5, 20);

        // Line with an empty FIFO: pixel holds, line length unchanged
        frame_pulse(1'b0);
        run_line(1'b0, 0, -1, 2000);
        chk("underflow_empty_line", err_underflow, 1);
        idle_cycles(3, 0);

        // Full frame: C_VIS lines, spurious line start, flush line, then an ignored start
        frame_pulse(1'b0);
        run_line(1'b0, 50, -1, 2000);
        idle_cycles(4, 30);
        run_line(1'b0, 50, 600, 2000);
        idle_cycles(2, 30);
        run_line(1'b0, 40, -1, 2000);
        idle_cycles(3, 30);
        run_line(1'b1, 40, -1, 2000);
        chk("flush_line_count", line_count, C_VIS + 1);
        ppu_line_start = 1'b1;
        tick();
        ppu_line_start = 1'b0;
        chk("extra_start_busy", busy, 0);
        chk("extra_start_no_error", err_underflow, exp_unf);
        idle_cycles(8, 20);
        chk("extra_start_line_count", line_count, C_VIS + 1);

        // Frame start at slot 100 of RUN, then frame and line together
        frame_pulse(1'b0);
        run_line(1'b0, 40, -1, 403);
        frame_pulse(1'b0);
        frame_pulse(1'b1);
        idle_cycles(2, 0);
        run_line(1'b0, 40, -1, 2000);
        idle_cycles(int'($urandom_range(1, 20)), 30);
        run_line(1'b0, int'($urandom_range(10, 70)), -1, 2000);

        // Asynchronous reset in the middle of RUN
        run_line(1'b0, 40, -1, 300);
        vga_x        = '0;
        vga_line_odd = 1'b0;
        reset = 1'b1;
        #2;
        q.delete();
        exp_pix = '0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        exp_lc  = 0;
        chk_all_reset_outputs();
        tick();
        chk_all_reset_outputs();
        reset = 1'b0;
        tick();
        chk("midrun_release_reset_frame", hq_reset_frame, 0);
        chk("midrun_release_busy", busy, 0);
        chk("midrun_release_pixel", hq_inputpixel, 0);
        idle_cycles(3, 30);
        run_line(1'b0, int'($urandom_range(20, 60)), -1, 2000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
